// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial BCD subtractor.
//   BCD digit constants, the FSM state encoding and a digit-range helper.
package bcd_serial_subtractor_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_RADIX   = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] dgt);
    return dgt > BCD_DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for bcd_serial_subtractor.
//   start/a/b    : request and packed-BCD operands (requester -> subtractor)
//   ready/done   : idle indication and one-cycle result strobe
//   diff/neg/invalid : |a-b| in packed BCD, sign, bad-digit flag
interface bcd_serial_subtractor_if #(parameter int DIGITS = 2);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  invalid;

  modport master (output start, a, b, input ready, done, diff, neg, invalid);
  modport slave  (input start, a, b, output ready, done, diff, neg, invalid);
endinterface

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// Combinational single-digit BCD subtract with borrow: d = x - y - bin (mod 10).
//   x, y : BCD digits (0..9)   bin : borrow in
//   d    : result digit        bout: borrow out (x - y - bin < 0)
module bcd_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  // Range of x-y-bin is -10..9, so a 5-bit two's-complement result suffices.
  logic [4:0] t;

  always_comb begin
    t    = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    bout = t[4];
    d    = bout ? (t[3:0] + 4'(BCD_RADIX)) : t[3:0];
  end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: |a - b| plus sign, one digit per clock.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of bcd_serial_subtractor_if (start/ready/done handshake,
//              operands a/b, results diff/neg/invalid)
//
//   state  | meaning
//   IDLE   | ready=1, waiting for start
//   SUB    | r = a - b, one digit per cycle
//   NEG    | r = 0 - r (ten's complement) when a < b
//   DONE   | publish result, pulse done next cycle
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_serial_subtractor_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [W-1:0]    r_q, r_d;
  logic            neg_pend_q, neg_pend_d;
  logic            inv_pend_q, inv_pend_d;
  logic            done_q, done_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            neg_q, neg_d;
  logic            invalid_q, invalid_d;

  logic            any_inv;
  logic [3:0]      ds_x, ds_y, ds_d;
  logic            ds_bout;
  logic            last_digit;

  // One digit slice serves both passes: SUB uses a/b, NEG uses 0/r.
  bcd_digit_sub u_digit_sub (
    .x    (ds_x),
    .y    (ds_y),
    .bin  (borrow_q),
    .d    (ds_d),
    .bout (ds_bout)
  );

  always_comb begin
    any_inv = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      any_inv = any_inv | digit_invalid(bus.a[4*i +: 4]) | digit_invalid(bus.b[4*i +: 4]);
    end
  end

  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign ds_x       = (state_q == S_NEG) ? 4'd0 : op_a_q[4*idx_q +: 4];
  assign ds_y       = (state_q == S_NEG) ? r_q[4*idx_q +: 4] : op_b_q[4*idx_q +: 4];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    borrow_d   = borrow_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    r_d        = r_q;
    neg_pend_d = neg_pend_q;
    inv_pend_d = inv_pend_q;
    done_d     = 1'b0;
    diff_d     = diff_q;
    neg_d      = neg_q;
    invalid_d  = invalid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_a_d     = bus.a;
          op_b_d     = bus.b;
          idx_d      = '0;
          borrow_d   = 1'b0;
          r_d        = '0;
          neg_pend_d = 1'b0;
          inv_pend_d = any_inv;
          state_d    = any_inv ? S_DONE : S_SUB;
        end
      end
      S_SUB, S_NEG: begin
        r_d[4*idx_q +: 4] = ds_d;
        borrow_d          = ds_bout;
        if (!last_digit) begin
          idx_d = idx_q + IW'(1);
        end else if (state_q == S_SUB && ds_bout) begin
          // Final borrow means a < b: r holds the ten's complement of |a-b|.
          idx_d      = '0;
          borrow_d   = 1'b0;
          neg_pend_d = 1'b1;
          state_d    = S_NEG;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        diff_d    = inv_pend_q ? '0 : r_q;
        neg_d     = inv_pend_q ? 1'b0 : neg_pend_q;
        invalid_d = inv_pend_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      r_q        <= '0;
      neg_pend_q <= 1'b0;
      inv_pend_q <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      neg_q      <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      borrow_q   <= borrow_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      r_q        <= r_d;
      neg_pend_q <= neg_pend_d;
      inv_pend_q <= inv_pend_d;
      done_q     <= done_d;
      diff_q     <= diff_d;
      neg_q      <= neg_d;
      invalid_q  <= invalid_d;
    end
  end

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.done    = done_q;
  assign bus.diff    = diff_q;
  assign bus.neg     = neg_q;
  assign bus.invalid = invalid_q;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (DIGITS=2).
module tb_bcd_serial_subtractor;
  import bcd_serial_subtractor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  bcd_serial_subtractor_if #(.DIGITS(2)) bus ();

  bcd_serial_subtractor #(.DIGITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Issue one request, wait (bounded) for done, check latency and results.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_diff, input logic exp_neg,
                        input logic exp_inv, input int exp_lat);
    int n;
    logic [7:0] prev_diff;
    logic       seen;
    @(negedge clk);
    prev_diff = bus.diff;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'h77;
    bus.b     = 8'h11;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      if (n == 0) chk({tag, "_hold"}, 32'(bus.diff), 32'(prev_diff));
      @(posedge clk);
      #1;
      n++;
      seen = bus.done;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
    chk({tag, "_neg"}, 32'(bus.neg), 32'(exp_neg));
    chk({tag, "_inv"}, 32'(bus.invalid), 32'(exp_inv));
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int ea, eb, n;
    logic seen;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_neg", 32'(bus.neg), 32'd0);
    chk("rst_inv", 32'(bus.invalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("t1", 8'h45, 8'h12, 8'h33, 1'b0, 1'b0, 3);
    run_op("t2", 8'h12, 8'h45, 8'h33, 1'b1, 1'b0, 5);
    run_op("eq", 8'h50, 8'h50, 8'h00, 1'b0, 1'b0, 3);
    run_op("zm", 8'h00, 8'h99, 8'h99, 1'b1, 1'b0, 5);
    run_op("mz", 8'h99, 8'h00, 8'h99, 1'b0, 1'b0, 3);
    run_op("brw", 8'h30, 8'h07, 8'h23, 1'b0, 1'b0, 3);
    run_op("inv", 8'h3A, 8'h12, 8'h00, 1'b0, 1'b1, 1);
    run_op("invb", 8'h12, 8'hF0, 8'h00, 1'b0, 1'b1, 1);

    // Start pulsed while busy must be ignored; only one done, first operands win.
    run_op("pre", 8'h12, 8'h45, 8'h33, 1'b1, 1'b0, 5);
    @(negedge clk);
    bus.a = 8'h45; bus.b = 8'h12; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 8'h99; bus.b = 8'h00;
    chk("busy_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_diff", 32'(bus.diff), 32'h33);
    chk("busy_neg", 32'(bus.neg), 32'd1);
    n = 1; seen = bus.done;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++; seen = bus.done;
    end
    chk("busy_done", 32'(seen), 32'd1);
    chk("busy_lat", n, 3);
    chk("busy_res", 32'(bus.diff), 32'h33);
    chk("busy_resneg", 32'(bus.neg), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | bus.done;
    end
    chk("busy_nodup", 32'(seen), 32'd0);

    // Reset in the middle of SUB clears everything on the next edge.
    run_op("pre2", 8'h12, 8'h45, 8'h33, 1'b1, 1'b0, 5);
    @(negedge clk);
    bus.a = 8'h20; bus.b = 8'h05; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ready", 32'(bus.ready), 32'd1);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_diff", 32'(bus.diff), 32'd0);
    chk("mrst_neg", 32'(bus.neg), 32'd0);
    chk("mrst_inv", 32'(bus.invalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | bus.done;
    end
    chk("mrst_nodone", 32'(seen), 32'd0);

    // Strided sweep against an integer model.
    for (int ia = 0; ia < 100; ia += 11) begin
      for (int ib = 3; ib < 100; ib += 13) begin
        ea = ia; eb = ib;
        run_op("sw", to_bcd(ea), to_bcd(eb),
               to_bcd((ea >= eb) ? ea - eb : eb - ea),
               (ea < eb), 1'b0, (ea >= eb) ? 3 : 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
